axis_burst_master: RTL and testbench



---
 rtl/axis_bm_pkg.sv | 29 ++
 rtl/axis_bm_fifo.sv | 59 +++++
 rtl/axis_burst_master.sv | 136 +++++++++++++
 tb/tb_axis_burst_master.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bm_pkg.sv
// Shared types and defaults for the AXI-Stream burst master.
// Holds the FSM state enum, default widths and the beat layout.
package axis_bm_pkg;

    localparam int DW_DEF    = 32;
    localparam int UW_DEF    = 2;
    localparam int DEPTH_DEF = 8;
    localparam int GW_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } bm_state_e;

    // Beat layout at default widths; FIFO words use the same field order.
    typedef struct packed {
        logic [DW_DEF-1:0]   data;
        logic [DW_DEF/8-1:0] strb;
        logic [DW_DEF/8-1:0] keep;
        logic [UW_DEF-1:0]   user;
        logic                last;
    } bm_beat_t;

    function automatic int beat_width(input int dw, input int uw);
        return dw + 2 * (dw / 8) + uw + 1;
    endfunction

endpackage

// File: rtl/axis_bm_fifo.sv
// Synchronous beat FIFO with wrap-bit pointers and registered level.
// Ports: push/pop requests, din/dout word, full/empty flags, level.
module axis_bm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axis_burst_master.sv
// AXI-Stream master replaying backdoor-pushed beats with gaps/counters.
// Ports: bk_* producer side, cfg_gap, status counters, axis_* master.
module axis_burst_master
    import axis_bm_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int UW    = UW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int GW    = GW_DEF
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic                     bk_valid,
    output logic                     bk_ready,
    input  logic [DW-1:0]            bk_data,
    input  logic [DW/8-1:0]          bk_tstrb,
    input  logic [DW/8-1:0]          bk_tkeep,
    input  logic [UW-1:0]            bk_user,
    input  logic                     bk_last,
    input  logic [GW-1:0]            cfg_gap,
    output logic [$clog2(DEPTH):0]   bk_level,
    output logic                     bk_done,
    output logic [31:0]              beat_cnt,
    output logic [15:0]              burst_cnt,
    output logic                     axis_tvalid,
    output logic [DW-1:0]            axis_tdata,
    output logic [DW/8-1:0]          axis_tstrb,
    output logic [DW/8-1:0]          axis_tkeep,
    output logic                     axis_tlast,
    output logic [UW-1:0]            axis_tuser,
    input  logic                     axis_tready
);

    localparam int BW = beat_width(DW, UW);

    bm_state_e        state;
    logic [GW-1:0]    gap_cnt;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [BW-1:0]    fifo_din;
    logic [BW-1:0]    fifo_dout;
    logic [DW-1:0]    nx_data;
    logic [DW/8-1:0]  nx_strb;
    logic [DW/8-1:0]  nx_keep;
    logic [UW-1:0]    nx_user;
    logic             nx_last;

    assign fifo_din = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last};
    assign {nx_data, nx_strb, nx_keep, nx_user, nx_last} = fifo_dout;
    assign bk_ready = !fifo_full;

    axis_bm_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (axi_aclk),
        .rst   (axi_areset),
        .push  (bk_valid),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bk_level)
    );

    // Pop in IDLE, or on a gapless handshake so SEND streams back-to-back.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            SEND:    fifo_pop = axis_tready && (cfg_gap == '0) && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            bk_done     <= 1'b0;
            beat_cnt    <= '0;
            burst_cnt   <= '0;
            axis_tvalid <= 1'b0;
            axis_tdata  <= '0;
            axis_tstrb  <= '0;
            axis_tkeep  <= '0;
            axis_tlast  <= 1'b0;
            axis_tuser  <= '0;
        end else begin
            bk_done <= 1'b0;
            if (fifo_pop) begin
                axis_tdata <= nx_data;
                axis_tstrb <= nx_strb;
                axis_tkeep <= nx_keep;
                axis_tuser <= nx_user;
                axis_tlast <= nx_last;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        axis_tvalid <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (axis_tready) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (axis_tlast) begin
                            burst_cnt <= burst_cnt + 16'd1;
                            bk_done   <= 1'b1;
                        end
                        if (cfg_gap != '0) begin
                            gap_cnt     <= cfg_gap;
                            axis_tvalid <= 1'b0;
                            state       <= GAP;
                        end else if (fifo_empty) begin
                            axis_tvalid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_burst_master.sv
// Directed bench for axis_burst_master.
// Each task drives one scenario and checks against hand-derived values.
module tb_axis_burst_master;

    localparam int DW    = 32;
    localparam int UW    = 2;
    localparam int DEPTH = 8;
    localparam int GW    = 4;
    localparam int SW    = DW / 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BW    = DW + 2 * SW + UW + 1;

    logic            axi_aclk;
    logic            axi_areset;
    logic            bk_valid;
    logic            bk_ready;
    logic [DW-1:0]   bk_data;
    logic [SW-1:0]   bk_tstrb;
    logic [SW-1:0]   bk_tkeep;
    logic [UW-1:0]   bk_user;
    logic            bk_last;
    logic [GW-1:0]   cfg_gap;
    logic [LW-1:0]   bk_level;
    logic            bk_done;
    logic [31:0]     beat_cnt;
    logic [15:0]     burst_cnt;
    logic            axis_tvalid;
    logic [DW-1:0]   axis_tdata;
    logic [SW-1:0]   axis_tstrb;
    logic [SW-1:0]   axis_tkeep;
    logic            axis_tlast;
    logic [UW-1:0]   axis_tuser;
    logic            axis_tready;
    logic [BW-1:0]   out_beat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic [BW-1:0] hs_beat[$];
    int            hs_cyc[$];

    axis_burst_master #(
        .DW    (DW),
        .UW    (UW),
        .DEPTH (DEPTH),
        .GW    (GW)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_areset  (axi_areset),
        .bk_valid    (bk_valid),
        .bk_ready    (bk_ready),
        .bk_data     (bk_data),
        .bk_tstrb    (bk_tstrb),
        .bk_tkeep    (bk_tkeep),
        .bk_user     (bk_user),
        .bk_last     (bk_last),
        .cfg_gap     (cfg_gap),
        .bk_level    (bk_level),
        .bk_done     (bk_done),
        .beat_cnt    (beat_cnt),
        .burst_cnt   (burst_cnt),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tready (axis_tready)
    );

    assign out_beat = {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    // Inputs change 1ns after posedge, so at negedge a valid&ready pair
    // is exactly the handshake the next posedge will take.
    always @(negedge axi_aclk) begin
        cyc++;
        if (axis_tvalid && axis_tready && !axi_areset) begin
            hs_beat.push_back(out_beat);
            hs_cyc.push_back(cyc);
        end
        if (bk_done) begin
            done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] mk(input int i, input logic l);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [SW-1:0] k;
        logic [UW-1:0] u;
        d = DW'((i + 1) * 17);
        s = SW'(1 << (i % SW));
        k = SW'(i + 8);
        u = UW'(i);
        return {d, s, k, u, l};
    endfunction

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] b);
        bk_valid = 1'b1;
        {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} = b;
    endtask

    task automatic do_reset();
        bk_valid    = 1'b0;
        axis_tready = 1'b0;
        cfg_gap     = '0;
        axi_areset  = 1'b1;
        step();
        axi_areset  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({axis_tvalid, out_beat, bk_done, bk_level, bk_ready} !==
            {1'b0, {BW{1'b0}}, 1'b0, {LW{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got v=%b beat=%h done=%b lvl=%0d rdy=%b exp zeros rdy=1",
                     axis_tvalid, out_beat, bk_done, bk_level, bk_ready);
        end
        total++;
        if ({beat_cnt, burst_cnt} !== 48'd0) begin
            bad++;
            $display("FAIL reset_counters got beat=%0d burst=%0d exp 0 0", beat_cnt, burst_cnt);
        end
        step();
        axi_areset = 1'b0;
        step();
        total++;
        if ({axis_tvalid, bk_level, bk_ready, beat_cnt} !== {1'b0, {LW{1'b0}}, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL post_reset got v=%b lvl=%0d rdy=%b beat=%0d exp 0 0 1 0",
                     axis_tvalid, bk_level, bk_ready, beat_cnt);
        end
    endtask

    task automatic test_single_burst();
        int b0;
        int d0;
        do_reset();
        axis_tready = 1'b1;
        b0 = hs_beat.size();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                total++;
                if (axis_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL single_latency_early got tvalid=%b exp 0", axis_tvalid);
                end
            end
            if (i == 2) begin
                total++;
                if ({axis_tvalid, axis_tdata} !== {1'b1, 32'h11}) begin
                    bad++;
                    $display("FAIL single_latency got v=%b data=%h exp 1 11", axis_tvalid, axis_tdata);
                end
            end
            push(mk(i, i == 3));
            step();
        end
        bk_valid = 1'b0;
        repeat (6) step();
        total++;
        if (hs_beat.size() - b0 !== 4) begin
            bad++;
            $display("FAIL single_count got %0d exp 4", hs_beat.size() - b0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (hs_beat[b0+k] !== mk(k, k == 3) || hs_cyc[b0+k] !== hs_cyc[b0] + k) begin
                    bad++;
                    $display("FAIL single_beat%0d got %h @%0d exp %h @%0d", k, hs_beat[b0+k],
                             hs_cyc[b0+k], mk(k, k == 3), hs_cyc[b0] + k);
                end
            end
        end
        total++;
        if ({done_cnt - d0, beat_cnt, burst_cnt} !== {32'd1, 32'd4, 16'd1}) begin
            bad++;
            $display("FAIL single_counters got done=%0d beat=%0d burst=%0d exp 1 4 1",
                     done_cnt - d0, beat_cnt, burst_cnt);
        end
    endtask

    task automatic test_backpressure();
        int b0;
        do_reset();
        b0 = hs_beat.size();
        for (int i = 0; i < 4; i++) begin
            push(mk(i, i == 3));
            step();
        end
        bk_valid = 1'b0;
        step();
        axis_tready = 1'b1;
        step();
        axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({axis_tvalid, out_beat} !== {1'b1, mk(1, 1'b0)}) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b beat=%h exp 1 %h", c, axis_tvalid, out_beat, mk(1, 1'b0));
            end
            step();
        end
        axis_tready = 1'b1;
        repeat (6) step();
        total++;
        if (hs_beat.size() - b0 !== 4) begin
            bad++;
            $display("FAIL bp_count got %0d exp 4", hs_beat.size() - b0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (hs_beat[b0+k] !== mk(k, k == 3)) begin
                    bad++;
                    $display("FAIL bp_beat%0d got %h exp %h", k, hs_beat[b0+k], mk(k, k == 3));
                end
            end
        end
        total++;
        if (beat_cnt !== 32'd4) begin
            bad++;
            $display("FAIL bp_beat_cnt got %0d exp 4", beat_cnt);
        end
    endtask

    task automatic test_gap();
        int b0;
        do_reset();
        cfg_gap     = 4'd3;
        axis_tready = 1'b1;
        b0 = hs_beat.size();
        for (int i = 0; i < 3; i++) begin
            push(mk(i, i == 2));
            step();
        end
        bk_valid = 1'b0;
        step();
        step();
        // Still inside the first gap: must not shorten it, applies to beat 2.
        cfg_gap = 4'd1;
        repeat (12) step();
        total++;
        if (hs_beat.size() - b0 !== 3) begin
            bad++;
            $display("FAIL gap_count got %0d exp 3", hs_beat.size() - b0);
        end else begin
            total++;
            if (hs_cyc[b0+1] - hs_cyc[b0] !== 5) begin
                bad++;
                $display("FAIL gap3_spacing got %0d exp 5", hs_cyc[b0+1] - hs_cyc[b0]);
            end
            total++;
            if (hs_cyc[b0+2] - hs_cyc[b0+1] !== 3) begin
                bad++;
                $display("FAIL gap1_spacing got %0d exp 3", hs_cyc[b0+2] - hs_cyc[b0+1]);
            end
            total++;
            if (hs_beat[b0+2] !== mk(2, 1'b1)) begin
                bad++;
                $display("FAIL gap_last_beat got %h exp %h", hs_beat[b0+2], mk(2, 1'b1));
            end
        end
    endtask

    task automatic test_full_fifo();
        int b0;
        logic [9:0] rdy;
        do_reset();
        b0 = hs_beat.size();
        for (int i = 0; i < 10; i++) begin
            push(mk(i, i == 8));
            rdy[i] = bk_ready;
            step();
        end
        // One beat sits in the output register, so DEPTH+1 are accepted.
        total++;
        if (rdy !== 10'b01_1111_1111) begin
            bad++;
            $display("FAIL full_ready got %b exp 0111111111", rdy);
        end
        total++;
        if ({bk_level, bk_ready, out_beat} !== {LW'(8), 1'b0, mk(0, 1'b0)}) begin
            bad++;
            $display("FAIL full_level got lvl=%0d rdy=%b beat=%h exp 8 0 %h",
                     bk_level, bk_ready, out_beat, mk(0, 1'b0));
        end
        axis_tready = 1'b1;
        step();
        bk_valid = 1'b0;
        total++;
        if ({bk_level, bk_ready} !== {LW'(7), 1'b1}) begin
            bad++;
            $display("FAIL full_no_refill got lvl=%0d rdy=%b exp 7 1", bk_level, bk_ready);
        end
        repeat (14) step();
        total++;
        if (hs_beat.size() - b0 !== 9) begin
            bad++;
            $display("FAIL full_count got %0d exp 9", hs_beat.size() - b0);
        end else begin
            for (int k = 0; k < 9; k++) begin
                total++;
                if (hs_beat[b0+k] !== mk(k, k == 8)) begin
                    bad++;
                    $display("FAIL full_beat%0d got %h exp %h", k, hs_beat[b0+k], mk(k, k == 8));
                end
            end
        end
        total++;
        if ({bk_level, beat_cnt, burst_cnt} !== {LW'(0), 32'd9, 16'd1}) begin
            bad++;
            $display("FAIL full_drain got lvl=%0d beat=%0d burst=%0d exp 0 9 1",
                     bk_level, beat_cnt, burst_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(mk(i, 1'b0));
            step();
        end
        bk_valid = 1'b0;
        step();
        step();
        axis_tready = 1'b1;
        step();
        axis_tready = 1'b0;
        total++;
        if ({axis_tvalid, bk_level, beat_cnt, out_beat} !== {1'b1, LW'(3), 32'd1, mk(1, 1'b0)}) begin
            bad++;
            $display("FAIL mid_pre got v=%b lvl=%0d beat=%0d data=%h exp 1 3 1 %h",
                     axis_tvalid, bk_level, beat_cnt, out_beat, mk(1, 1'b0));
        end
        #2;
        axi_areset = 1'b1;
        #1;
        total++;
        if ({axis_tvalid, bk_level, bk_ready, beat_cnt, burst_cnt, out_beat} !==
            {1'b0, LW'(0), 1'b1, 32'd0, 16'd0, {BW{1'b0}}}) begin
            bad++;
            $display("FAIL mid_async got v=%b lvl=%0d rdy=%b beat=%0d burst=%0d data=%h exp 0 0 1 0 0 0",
                     axis_tvalid, bk_level, bk_ready, beat_cnt, burst_cnt, out_beat);
        end
        step();
        axi_areset = 1'b0;
        b0 = hs_beat.size();
        axis_tready = 1'b1;
        push(mk(7, 1'b1));
        step();
        bk_valid = 1'b0;
        repeat (5) step();
        total++;
        if (hs_beat.size() - b0 !== 1) begin
            bad++;
            $display("FAIL mid_new_count got %0d exp 1", hs_beat.size() - b0);
        end else begin
            total++;
            if (hs_beat[b0] !== mk(7, 1'b1)) begin
                bad++;
                $display("FAIL mid_new_beat got %h exp %h", hs_beat[b0], mk(7, 1'b1));
            end
        end
        total++;
        if ({bk_level, beat_cnt, burst_cnt} !== {LW'(0), 32'd1, 16'd1}) begin
            bad++;
            $display("FAIL mid_post got lvl=%0d beat=%0d burst=%0d exp 0 1 1",
                     bk_level, beat_cnt, burst_cnt);
        end
    endtask

    task automatic test_wrap();
        int d0;
        do_reset();
        force dut.burst_cnt = 16'hFFFF;
        force dut.beat_cnt  = 32'hFFFF_FFFF;
        #1;
        release dut.burst_cnt;
        release dut.beat_cnt;
        d0 = done_cnt;
        axis_tready = 1'b1;
        push(mk(2, 1'b1));
        step();
        bk_valid = 1'b0;
        repeat (5) step();
        total++;
        if ({burst_cnt, beat_cnt, done_cnt - d0} !== {16'h0000, 32'h0, 32'd1}) begin
            bad++;
            $display("FAIL wrap got burst=%h beat=%h done=%0d exp 0000 00000000 1",
                     burst_cnt, beat_cnt, done_cnt - d0);
        end
    endtask

    initial begin
        axi_areset  = 1'b1;
        bk_valid    = 1'b0;
        bk_data     = '0;
        bk_tstrb    = '0;
        bk_tkeep    = '0;
        bk_user     = '0;
        bk_last     = 1'b0;
        cfg_gap     = '0;
        axis_tready = 1'b0;
        test_reset();
        test_single_burst();
        test_backpressure();
        test_gap();
        test_full_fifo();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
